// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_pkg
//  Purpose  : Shared types, constants and helpers for the SRAM byte-port
//             arbiter: controller state encoding, access-size codes, SRAM
//             address width and the big-endian byte-lane selector.
//  Revision : 1.0  initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 8;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } state_e;

    // Byte k of a word is taken big-endian (k=0 -> bits [31:24]).
    // Byte accesses always use the low byte regardless of k.
    function automatic logic [7:0] pick_byte(input logic [31:0] data,
                                             input logic        size,
                                             input logic [1:0]  k);
        logic [7:0] b;
        b = data[7:0];
        if (size == SIZE_WORD) begin
            case (k)
                2'd0:    b = data[31:24];
                2'd1:    b = data[23:16];
                2'd2:    b = data[15:8];
                default: b = data[7:0];
            endcase
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way arbiter with a last-grant pointer. Round-robin on a
//             tie, or fixed priority to requester 0 when FIXED_PRIO = 1.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             req_i[1:0]      - request vector
//             update_i        - commit the current grant to the pointer
//             gnt_o[1:0]      - one-hot grant (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // 1 = requester 1 was granted last. Resets to 1 so requester 0 wins first.
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (FIXED_PRIO || last_q) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update_i && (|req_i)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Arbitrates two masters onto the byte-wide SRAM read/write port
//             and splits word requests into four big-endian byte accesses.
//  Ports    : clk, rst               - clock, asynchronous active-high reset
//             mN_req/we/size/addr/wdata - master N request (N = 0, 1)
//             mN_ack, mN_rdata       - completion pulse, read result
//             rw_addr, w, w_en       - registered SRAM byte address/data/enable
//             r                      - SRAM read byte (one cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic                   m0_size,
    input  logic [7:0]             m0_addr,
    input  logic [31:0]            m0_wdata,
    output logic                   m0_ack,
    output logic [31:0]            m0_rdata,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic                   m1_size,
    input  logic [7:0]             m1_addr,
    input  logic [31:0]            m1_wdata,
    output logic                   m1_ack,
    output logic [31:0]            m1_rdata,
    output logic [SRAM_ADDR_W-1:0] rw_addr,
    output logic [7:0]             w,
    output logic                   w_en,
    input  logic [7:0]             r
);

    state_e state_q, state_d;

    logic [1:0]             gnt;
    logic                   arb_update;
    logic                   last_beat;

    // Winner's request, selected from the grant.
    logic                   win_we;
    logic                   win_size;
    logic [7:0]             win_addr;
    logic [31:0]            win_wdata;
    logic [SRAM_ADDR_W-1:0] win_base;

    // Latched transaction.
    logic                   sel_q;
    logic                   we_q;
    logic                   size_q;
    logic [SRAM_ADDR_W-1:0] base_q;
    logic [31:0]            wdata_q;
    logic [1:0]             cnt_q;
    logic [31:0]            buf_q;

    logic [SRAM_ADDR_W-1:0] rw_addr_q;
    logic [7:0]             w_q;
    logic                   w_en_q;
    logic                   m0_ack_q, m1_ack_q;
    logic [31:0]            m0_rdata_q, m1_rdata_q;

    assign arb_update = (state_q == IDLE);

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({m1_req, m0_req}),
        .update_i (arb_update),
        .gnt_o    (gnt)
    );

    always_comb begin
        win_we    = gnt[1] ? m1_we    : m0_we;
        win_size  = gnt[1] ? m1_size  : m0_size;
        win_addr  = gnt[1] ? m1_addr  : m0_addr;
        win_wdata = gnt[1] ? m1_wdata : m0_wdata;
        // Word accesses are forced to the aligned base.
        win_base  = (win_size == SIZE_WORD) ? {win_addr[7:2], 2'b00} : win_addr;
    end

    assign last_beat = (size_q == SIZE_BYTE) || (cnt_q == 2'd3);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|gnt) state_d = ISSUE;
            ISSUE:   if (last_beat) state_d = DRAIN;
            DRAIN:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // SRAM outputs are registered, so the first byte is presented by the
    // same edge that grants. Read bytes arrive one cycle after their address,
    // hence the buffer shifts in from the second ISSUE cycle through DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            base_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= 2'd0;
            buf_q      <= '0;
            rw_addr_q  <= '0;
            w_q        <= '0;
            w_en_q     <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            w_en_q   <= 1'b0;
            m0_ack_q <= (state_q == DRAIN) && !sel_q;
            m1_ack_q <= (state_q == DRAIN) &&  sel_q;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        sel_q     <= gnt[1];
                        we_q      <= win_we;
                        size_q    <= win_size;
                        base_q    <= win_base;
                        wdata_q   <= win_wdata;
                        cnt_q     <= 2'd0;
                        buf_q     <= '0;
                        rw_addr_q <= win_base;
                        w_q       <= pick_byte(win_wdata, win_size, 2'd0);
                        w_en_q    <= win_we;
                    end
                end
                ISSUE: begin
                    if (cnt_q != 2'd0) begin
                        buf_q <= {buf_q[23:0], r};
                    end
                    if (!last_beat) begin
                        cnt_q     <= cnt_q + 2'd1;
                        rw_addr_q <= base_q + {6'd0, cnt_q} + 8'd1;
                        w_q       <= pick_byte(wdata_q, size_q, cnt_q + 2'd1);
                        w_en_q    <= we_q;
                    end
                end
                DRAIN: begin
                    if (!we_q) begin
                        if (sel_q) begin
                            m1_rdata_q <= {buf_q[23:0], r};
                        end else begin
                            m0_rdata_q <= {buf_q[23:0], r};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rw_addr  = rw_addr_q;
    assign w        = w_q;
    assign w_en     = w_en_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule
`default_nettype wire
